// File: rtl/ftoi_pipe.sv
// ftoi_pipe: three-stage binary32 to int32 converter, round half away from zero, saturating
module ftoi_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);
    logic        v1, v2, r1, r2, r3;
    logic        s1, zero1, sat1, exact1;
    logic [4:0]  sh1;
    logic [23:0] mant1;
    logic        s2, sat2, exact2, rnd2;
    logic [30:0] int2;
    logic [30:0] int_w;
    logic        rnd_w;
    logic [31:0] mag;
    logic        nan;

    assign r3       = !out_valid || out_ready;
    assign r2       = !v2 || r3;
    assign r1       = !v1 || r2;
    assign in_ready = r1;
    assign nan      = (x[30:23] == 8'hff) && (x[22:0] != 23'd0);

    // Shifting mant by (e-126) leaves the integer part above bit 23 and the round bit at 23
    assign {int_w, rnd_w} = 32'(({31'd0, mant1} << sh1) >> 23);
    assign mag            = {1'b0, int2} + {31'd0, rnd2};

    // S1: unpack and classify; NaN is folded into positive saturation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1     <= 1'b0;
            s1     <= 1'b0;
            zero1  <= 1'b0;
            sat1   <= 1'b0;
            exact1 <= 1'b0;
            sh1    <= 5'd0;
            mant1  <= 24'd0;
        end else if (r1) begin
            v1     <= in_valid;
            s1     <= x[31] && !nan;
            zero1  <= x[30:23] <= 8'd125;
            sat1   <= x[30:23] >= 8'd158;
            exact1 <= x == 32'hcf000000;
            sh1    <= x[27:23] + 5'd2;
            mant1  <= {1'b1, x[22:0]};
        end
    end

    // S2: capture shifted integer part and round bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2     <= 1'b0;
            s2     <= 1'b0;
            sat2   <= 1'b0;
            exact2 <= 1'b0;
            int2   <= 31'd0;
            rnd2   <= 1'b0;
        end else if (r2) begin
            v2     <= v1;
            s2     <= s1;
            sat2   <= sat1;
            exact2 <= exact1;
            int2   <= zero1 ? 31'd0 : int_w;
            rnd2   <= !zero1 && rnd_w;
        end
    end

    // S3: round, negate, saturate; result held while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            y         <= 32'd0;
            ovf       <= 1'b0;
        end else if (r3) begin
            out_valid <= v2;
            if (v2) begin
                y   <= sat2 ? (s2 ? 32'h80000000 : 32'h7fffffff) : (s2 ? -mag : mag);
                ovf <= sat2 && !exact2;
            end
        end
    end
endmodule
